// File: rtl/mult_fu_pipe.sv
// mult_fu_pipe: pipelined 64x64 multiplier FU with bubble-collapsing stages, CDB backpressure and rollback squash
module mult_fu_pipe #(
  parameter int NUM_STAGE = 4,
  parameter int ROB_W = 5,
  parameter int PR_W = 6,
  parameter logic [PR_W-1:0] ZERO_PR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              issue_valid,
  input  logic [1:0]        func,
  input  logic [63:0]       opa,
  input  logic [63:0]       opb,
  input  logic [PR_W-1:0]   T_idx_in,
  input  logic [ROB_W-1:0]  ROB_idx_in,
  input  logic [4:0]        dest_idx_in,
  input  logic              rollback_en,
  input  logic [ROB_W-1:0]  ROB_rollback_idx,
  input  logic [ROB_W-1:0]  diff_ROB,
  input  logic              CDB_valid,
  output logic              ready,
  output logic              done,
  output logic [PR_W-1:0]   T_idx,
  output logic [ROB_W-1:0]  ROB_idx,
  output logic [4:0]        dest_idx,
  output logic [63:0]       result
);
  localparam int L = NUM_STAGE - 1;
  localparam int C = 64 / NUM_STAGE;

  logic [NUM_STAGE-1:0] v_q, v_d, kill, adv;
  logic [1:0]       f_q   [NUM_STAGE], f_d   [NUM_STAGE];
  logic [PR_W-1:0]  t_q   [NUM_STAGE], t_d   [NUM_STAGE];
  logic [ROB_W-1:0] rob_q [NUM_STAGE], rob_d [NUM_STAGE];
  logic [4:0]       dst_q [NUM_STAGE], dst_d [NUM_STAGE];
  logic [63:0]      a_q   [NUM_STAGE], a_d   [NUM_STAGE];
  logic [63:0]      b_q   [NUM_STAGE], b_d   [NUM_STAGE];
  logic [127:0]     s_q   [NUM_STAGE], s_d   [NUM_STAGE];
  logic hand, free0, hit_in, fr;

  function automatic logic [127:0] pp(input logic [63:0] a, input logic [63:0] b, input int k);
    return (128'(a) * ((128'(b) >> (k * C)) & ((128'(1) << C) - 128'(1)))) << (k * C);
  endfunction

  // Squashed entries still occupy their slot this cycle; only the last stage's done is masked.
  always_comb begin
    kill = '0;
    adv = '0;
    for (int i = 0; i < NUM_STAGE; i++)
      kill[i] = rollback_en && (ROB_W'(rob_q[i] - ROB_rollback_idx) <= diff_ROB);
    hit_in = rollback_en && (ROB_W'(ROB_idx_in - ROB_rollback_idx) <= diff_ROB);
    done = v_q[L] && !kill[L];
    hand = done && CDB_valid && en;
    adv[L] = hand;
    fr = !v_q[L] || hand;
    for (int i = L - 1; i >= 0; i--) begin
      adv[i] = en && v_q[i] && fr;
      fr = !v_q[i] || adv[i];
    end
    free0 = fr;
    ready = en && free0;
  end

  always_comb begin
    v_d = v_q;
    f_d = f_q;
    t_d = t_q;
    rob_d = rob_q;
    dst_d = dst_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    if (en) begin
      v_d[0] = free0 ? issue_valid && !hit_in : v_q[0] && !kill[0];
      if (free0) begin
        f_d[0] = func;
        t_d[0] = T_idx_in;
        rob_d[0] = ROB_idx_in;
        dst_d[0] = dest_idx_in;
        a_d[0] = opa;
        b_d[0] = opb;
        s_d[0] = pp(opa, opb, 0);
      end
      for (int i = 1; i < NUM_STAGE; i++) begin
        v_d[i] = adv[i-1] ? v_q[i-1] && !kill[i-1] : !adv[i] && v_q[i] && !kill[i];
        if (adv[i-1]) begin
          f_d[i] = f_q[i-1];
          t_d[i] = t_q[i-1];
          rob_d[i] = rob_q[i-1];
          dst_d[i] = dst_q[i-1];
          a_d[i] = a_q[i-1];
          b_d[i] = b_q[i-1];
          s_d[i] = s_q[i-1] + pp(a_q[i-1], b_q[i-1], i);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    v_q <= reset ? '0 : v_d;
    f_q <= f_d;
    t_q <= t_d;
    rob_q <= rob_d;
    dst_q <= dst_d;
    a_q <= a_d;
    b_q <= b_d;
    s_q <= s_d;
  end

  always_comb begin
    T_idx = v_q[L] ? t_q[L] : ZERO_PR;
    ROB_idx = v_q[L] ? rob_q[L] : '0;
    dest_idx = v_q[L] ? dst_q[L] : '0;
    result = !v_q[L] ? '0 :
             f_q[L] == 2'd1 ? s_q[L][127:64] :
             f_q[L] == 2'd2 ? {{32{s_q[L][31]}}, s_q[L][31:0]} : s_q[L][63:0];
  end
endmodule
